phase_sequencer: RTL and testbench

- Parametrised one-hot instruction-phase sequencer for the CPU control path. It generalises the fixed fetch/decode/execute/increment ring to NUM_PHASES phases.
- Adds per-cycle stall, a restart that jumps back to phase 0 (short instructions), halt/resume at instruction boundaries, and a completed-instruction counter.
- Drives the decoder's phase strobes. Phase 0 is always the fetch phase.

---
 rtl/phase_sequencer_if.sv | 29 ++
 rtl/phase_sequencer.sv | 93 +++++++++
 tb/tb_phase_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the CPU control path and the phase sequencer.
// The master drives the per-cycle controls and the slave returns the phase strobes and status.
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int COUNT_W    = 8
);
  localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic                  clock_enable;
  logic                  stall;
  logic                  restart;
  logic                  halt_req;
  logic                  resume;
  logic [NUM_PHASES-1:0] phase;
  logic [IDX_W-1:0]      phase_index;
  logic                  halted;
  logic                  cycle_done;
  logic [COUNT_W-1:0]    instr_count;

  modport master (
    output clock_enable, stall, restart, halt_req, resume,
    input  phase, phase_index, halted, cycle_done, instr_count
  );

  modport slave (
    input  clock_enable, stall, restart, halt_req, resume,
    output phase, phase_index, halted, cycle_done, instr_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// One-hot instruction-phase ring with stall, restart, halt/resume at instruction
// boundaries and a wrapping completed-instruction counter. All outputs come straight from flops.
module phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int COUNT_W    = 8
) (
  input  logic             clock_i,
  input  logic             clear_i,
  phase_sequencer_if.slave seq_if
);
  localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [NUM_PHASES-1:0] PHASE0 = {{(NUM_PHASES-1){1'b0}}, 1'b1};

  typedef enum logic {ST_RUN, ST_HALTED} state_e;

  state_e                state_q;
  logic [NUM_PHASES-1:0] phase_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  done_q;
  logic [COUNT_W-1:0]    count_q;

  logic phase_seen;
  logic phase_multi;
  logic phase_ok;
  logic at_last;

  // A phase vector is legal only with exactly one bit set.
  always_comb begin
    phase_seen  = 1'b0;
    phase_multi = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      phase_multi = phase_multi | (phase_seen & phase_q[i]);
      phase_seen  = phase_seen | phase_q[i];
    end
  end

  assign phase_ok = phase_seen & ~phase_multi;
  assign at_last  = phase_q[NUM_PHASES-1];

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      state_q <= ST_RUN;
      phase_q <= PHASE0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else if (seq_if.clock_enable) begin
      done_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (seq_if.restart || !phase_ok) begin
            phase_q <= PHASE0;
            idx_q   <= '0;
          end else if (seq_if.stall) begin
            phase_q <= phase_q;
          end else if (!at_last) begin
            phase_q <= {phase_q[NUM_PHASES-2:0], 1'b0};
            idx_q   <= idx_q + IDX_W'(1);
          end else begin
            count_q <= count_q + COUNT_W'(1);
            done_q  <= 1'b1;
            idx_q   <= '0;
            // Halting parks the ring with every strobe low until resume.
            if (seq_if.halt_req) begin
              state_q <= ST_HALTED;
              phase_q <= '0;
            end else begin
              phase_q <= PHASE0;
            end
          end
        end
        ST_HALTED: begin
          if (seq_if.resume) begin
            state_q <= ST_RUN;
            phase_q <= PHASE0;
            idx_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          phase_q <= PHASE0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign seq_if.phase       = phase_q;
  assign seq_if.phase_index = idx_q;
  assign seq_if.halted      = (state_q == ST_HALTED);
  assign seq_if.cycle_done  = done_q;
  assign seq_if.instr_count = count_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed table-driven bench for the phase sequencer: a 4-phase/8-bit instance
// driven from a vector table plus hand sequences, and a 6-phase/3-bit instance for the ring/wrap case.
module tb_phase_sequencer;
  logic clk;
  logic clear;

  int checks;
  int failures;

  phase_sequencer_if #(.NUM_PHASES(4), .COUNT_W(8)) bus4 ();
  phase_sequencer_if #(.NUM_PHASES(6), .COUNT_W(3)) bus6 ();

  phase_sequencer #(.NUM_PHASES(4), .COUNT_W(8)) dut4 (
    .clock_i (clk),
    .clear_i (clear),
    .seq_if  (bus4.slave)
  );

  phase_sequencer #(.NUM_PHASES(6), .COUNT_W(3)) dut6 (
    .clock_i (clk),
    .clear_i (clear),
    .seq_if  (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ce;
    logic       stall;
    logic       restart;
    logic       halt;
    logic       resume;
    logic [3:0] ph;
    logic [1:0] idx;
    logic       h;
    logic       d;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ce, input logic st, input logic rs,
                              input logic hr, input logic re, input logic [3:0] ph,
                              input logic [1:0] idx, input logic h, input logic d,
                              input logic [7:0] cnt);
    vec_t v;
    v.ce = ce; v.stall = st; v.restart = rs; v.halt = hr; v.resume = re;
    v.ph = ph; v.idx = idx; v.h = h; v.d = d; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [31:0] pack4();
    return {16'h0, bus4.halted, bus4.cycle_done, bus4.phase, bus4.phase_index, bus4.instr_count};
  endfunction

  function automatic logic [31:0] want4(input logic h, input logic d, input logic [3:0] ph,
                                        input logic [1:0] idx, input logic [7:0] cnt);
    return {16'h0, h, d, ph, idx, cnt};
  endfunction

  function automatic logic [31:0] pack6();
    return {16'h0, bus6.halted, bus6.cycle_done, bus6.phase, bus6.phase_index, bus6.instr_count};
  endfunction

  function automatic logic [31:0] want6(input logic h, input logic d, input logic [5:0] ph,
                                        input logic [2:0] idx, input logic [2:0] cnt);
    return {16'h0, 2'b00, h, d, ph, idx, cnt};
  endfunction

  task automatic drive4(input logic ce, input logic st, input logic rs, input logic hr, input logic re);
    bus4.clock_enable = ce;
    bus4.stall        = st;
    bus4.restart      = rs;
    bus4.halt_req     = hr;
    bus4.resume       = re;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus6.clock_enable = 1'b0;
    bus6.stall        = 1'b0;
    bus6.restart      = 1'b0;
    bus6.halt_req     = 1'b0;
    bus6.resume       = 1'b0;

    // ce, stall, restart, halt_req, resume | phase, idx, halted, done, count
    vecs.push_back(mk(1,0,0,0,0, 4'b0010,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b0100,2,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b1000,3,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 4'b0001,0,0,1,1));
    vecs.push_back(mk(1,0,0,0,0, 4'b0010,1,0,0,1));
    vecs.push_back(mk(1,0,0,0,0, 4'b0100,2,0,0,1));
    vecs.push_back(mk(1,0,0,0,0, 4'b1000,3,0,0,1));
    vecs.push_back(mk(1,0,0,0,0, 4'b0001,0,0,1,2));
    vecs.push_back(mk(1,0,0,0,0, 4'b0010,1,0,0,2));
    vecs.push_back(mk(1,0,0,0,0, 4'b0100,2,0,0,2));
    vecs.push_back(mk(1,1,0,0,0, 4'b0100,2,0,0,2));
    vecs.push_back(mk(1,1,0,0,0, 4'b0100,2,0,0,2));
    vecs.push_back(mk(1,1,0,0,0, 4'b0100,2,0,0,2));
    vecs.push_back(mk(0,0,0,0,0, 4'b0100,2,0,0,2));
    vecs.push_back(mk(0,0,1,0,0, 4'b0100,2,0,0,2));
    vecs.push_back(mk(0,0,0,1,0, 4'b0100,2,0,0,2));
    vecs.push_back(mk(0,1,0,0,1, 4'b0100,2,0,0,2));
    vecs.push_back(mk(0,0,0,0,0, 4'b0100,2,0,0,2));
    vecs.push_back(mk(1,0,0,0,0, 4'b1000,3,0,0,2));
    vecs.push_back(mk(1,0,0,0,0, 4'b0001,0,0,1,3));
    vecs.push_back(mk(0,0,1,0,0, 4'b0001,0,0,1,3));
    vecs.push_back(mk(0,0,0,1,0, 4'b0001,0,0,1,3));
    vecs.push_back(mk(1,0,0,0,0, 4'b0010,1,0,0,3));
    vecs.push_back(mk(1,0,0,0,0, 4'b0100,2,0,0,3));
    vecs.push_back(mk(1,1,1,0,0, 4'b0001,0,0,0,3));
    vecs.push_back(mk(1,0,0,0,0, 4'b0010,1,0,0,3));
    vecs.push_back(mk(1,0,0,0,0, 4'b0100,2,0,0,3));
    vecs.push_back(mk(1,0,0,0,0, 4'b1000,3,0,0,3));
    vecs.push_back(mk(1,0,1,0,0, 4'b0001,0,0,0,3));
    vecs.push_back(mk(1,0,0,1,0, 4'b0010,1,0,0,3));
    vecs.push_back(mk(1,0,0,1,0, 4'b0100,2,0,0,3));
    vecs.push_back(mk(1,1,0,1,0, 4'b0100,2,0,0,3));
    vecs.push_back(mk(1,0,0,1,0, 4'b1000,3,0,0,3));
    vecs.push_back(mk(1,0,0,1,0, 4'b0000,0,1,1,4));
    vecs.push_back(mk(1,0,0,0,0, 4'b0000,0,1,0,4));
    vecs.push_back(mk(1,1,1,0,0, 4'b0000,0,1,0,4));
    vecs.push_back(mk(1,0,0,1,0, 4'b0000,0,1,0,4));
    vecs.push_back(mk(0,0,0,0,1, 4'b0000,0,1,0,4));
    vecs.push_back(mk(1,0,0,0,0, 4'b0000,0,1,0,4));
    vecs.push_back(mk(1,0,0,0,1, 4'b0001,0,0,0,4));
    vecs.push_back(mk(1,0,0,0,0, 4'b0010,1,0,0,4));
    vecs.push_back(mk(1,0,0,0,1, 4'b0100,2,0,0,4));
    vecs.push_back(mk(1,0,0,1,1, 4'b1000,3,0,0,4));
    vecs.push_back(mk(1,1,0,1,0, 4'b1000,3,0,0,4));
    vecs.push_back(mk(1,0,0,0,0, 4'b0001,0,0,1,5));
    vecs.push_back(mk(1,0,0,0,0, 4'b0010,1,0,0,5));
    vecs.push_back(mk(1,0,0,0,0, 4'b0100,2,0,0,5));

    clear = 1'b1;
    #1;
    check("reset4", pack4(), want4(1'b0, 1'b0, 4'b0001, 2'd0, 8'd0));
    check("reset6", pack6(), want6(1'b0, 1'b0, 6'b000001, 3'd0, 3'd0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive4(vecs[i].ce, vecs[i].stall, vecs[i].restart, vecs[i].halt, vecs[i].resume);
      @(posedge clk);
      #1;
      $display("vec %0d phase=%b idx=%0d halted=%b done=%b count=%0d",
               i, bus4.phase, bus4.phase_index, bus4.halted, bus4.cycle_done, bus4.instr_count);
      check($sformatf("vec%0d", i), pack4(),
            want4(vecs[i].h, vecs[i].d, vecs[i].ph, vecs[i].idx, vecs[i].cnt));
    end

    // Asynchronous clear between edges while in phase 2 with count 5.
    @(negedge clk);
    drive4(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    clear = 1'b1;
    #1;
    $display("async clear phase=%b count=%0d", bus4.phase, bus4.instr_count);
    check("async_clear", pack4(), want4(1'b0, 1'b0, 4'b0001, 2'd0, 8'd0));
    @(posedge clk);
    #1;
    check("clear_held", pack4(), want4(1'b0, 1'b0, 4'b0001, 2'd0, 8'd0));
    @(negedge clk);
    clear = 1'b0;

    // 256 uninterrupted instructions wrap the 8-bit counter back to zero.
    for (int c = 1; c <= 1024; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) check("wrap_first", pack4(), want4(1'b0, 1'b1, 4'b0001, 2'd0, 8'd1));
      if (c == 1020) check("wrap_255", pack4(), want4(1'b0, 1'b1, 4'b0001, 2'd0, 8'd255));
      if (c == 1024) check("wrap_0", pack4(), want4(1'b0, 1'b1, 4'b0001, 2'd0, 8'd0));
    end
    $display("wrap count=%0d done=%b", bus4.instr_count, bus4.cycle_done);

    // Six-phase ring with a 3-bit counter wrapping after 8 instructions.
    @(negedge clk);
    drive4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    #1;
    check("reset6_again", pack6(), want6(1'b0, 1'b0, 6'b000001, 3'd0, 3'd0));
    @(negedge clk);
    clear = 1'b0;
    bus6.clock_enable = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      logic [5:0] ph6;
      ph6 = 6'b000001 << (c % 6);
      @(posedge clk);
      #1;
      $display("p6 cycle %0d phase=%b idx=%0d done=%b count=%0d",
               c, bus6.phase, bus6.phase_index, bus6.cycle_done, bus6.instr_count);
      check($sformatf("p6_c%0d", c), pack6(),
            want6(1'b0, (c % 6) == 0, ph6, 3'(c % 6), 3'((c / 6) % 8)));
    end
    bus6.clock_enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
